// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and counter sizing.
// The receiver imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CTS,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        LINE_IDLE   = 1'b1;
  localparam logic        START_LEVEL = 1'b0;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs (cts, rx).
// Clears to 0 on reset.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with valid/ready byte intake and rts/cts flow control.
// Bytes go out LSB first; tx and all status outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned USE_CTS      = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       busy,
  output logic       tx,
  output logic       rts,
  input  logic       cts
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT * STOP_BITS);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  uart_state_e          state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rts_q;
  logic                 cts_sync;

  uart_sync2 u_cts_sync (
    .clk_i (clock),
    .rst_ni(reset),
    .d_i   (cts),
    .q_o   (cts_sync)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rts_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid && ready_q) begin
            shift_q <= tx_data;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            rts_q   <= 1'b1;
            state_q <= WAIT_CTS;
          end
        end
        WAIT_CTS: begin
          if ((USE_CTS == 0) || cts_sync) begin
            tx_q      <= START_LEVEL;
            clk_cnt_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            // Bit counter wraps to 0 after the last data bit.
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == DATA_LAST) begin
              tx_q    <= LINE_IDLE;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (clk_cnt_q == STOP_LAST) begin
            clk_cnt_q <= '0;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            rts_q     <= 1'b0;
            state_q   <= IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign rts      = rts_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed/randomised bench for uart_tx: three instances cover 8N1 with cts,
// 8N2 back-to-back, and cts ignored; the line is checked against a frame model.
module tb_uart_tx;

  localparam int unsigned C    = 4;
  localparam int unsigned NONE = 9999;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cts;
  logic [1:0] sel;

  logic [2:0] v_i, rdy, done, bsy, txl, rts;
  logic       o_tx, o_rdy, o_done, o_bsy, o_rts;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign v_i[0] = tx_valid && (sel == 2'd0);
  assign v_i[1] = tx_valid && (sel == 2'd1);
  assign v_i[2] = tx_valid && (sel == 2'd2);

  assign o_tx   = txl[sel];
  assign o_rdy  = rdy[sel];
  assign o_done = done[sel];
  assign o_bsy  = bsy[sel];
  assign o_rts  = rts[sel];

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1), .USE_CTS(1)) u0 (
    .clock(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(v_i[0]),
    .tx_ready(rdy[0]), .tx_done(done[0]), .busy(bsy[0]), .tx(txl[0]),
    .rts(rts[0]), .cts(cts)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2), .USE_CTS(1)) u1 (
    .clock(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(v_i[1]),
    .tx_ready(rdy[1]), .tx_done(done[1]), .busy(bsy[1]), .tx(txl[1]),
    .rts(rts[1]), .cts(cts)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1), .USE_CTS(0)) u2 (
    .clock(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(v_i[2]),
    .tx_ready(rdy[2]), .tx_done(done[2]), .busy(bsy[2]), .tx(txl[2]),
    .rts(rts[2]), .cts(cts)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  // Line level k cycles after the start bit began: start, 8 data LSB first, then stop.
  function automatic logic line_model(input logic [7:0] b, input int unsigned k);
    int unsigned idx;
    idx = k / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] b);
    chk("ready_before_accept", o_rdy, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    step;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("ready_after_accept", o_rdy, 1'b0);
    chk("busy_after_accept", o_bsy, 1'b1);
    chk("rts_after_accept", o_rts, 1'b1);
    chk("tx_idle_in_wait", o_tx, 1'b1);
    chk("done_after_accept", o_done, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] b, input int unsigned s,
                           input int unsigned poke_k, input int unsigned drop_k);
    for (int unsigned k = 0; k < (9 + s) * C; k++) begin
      if (k == poke_k) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end else if (k == poke_k + 1) begin
        tx_valid = 1'b0;
      end
      if (k == drop_k) cts = 1'b0;
      step;
      chk("tx_line", o_tx, line_model(b, k));
      chk("rts_in_frame", o_rts, 1'b1);
      chk("busy_in_frame", o_bsy, 1'b1);
      chk("ready_in_frame", o_rdy, 1'b0);
      chk("done_in_frame", o_done, 1'b0);
    end
    step;
    chk("done_pulse", o_done, 1'b1);
    chk("ready_at_done", o_rdy, 1'b1);
    chk("busy_at_done", o_bsy, 1'b0);
    chk("rts_at_done", o_rts, 1'b0);
    chk("tx_at_done", o_tx, 1'b1);
  endtask

  task automatic idle_check;
    step;
    chk("done_one_cycle", o_done, 1'b0);
    chk("busy_idle", o_bsy, 1'b0);
    chk("tx_idle", o_tx, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    rst_n    = 1'b0;
    sel      = 2'd0;
    tx_valid = 1'b0;
    cts      = 1'b0;
    tx_data  = '0;

    for (int i = 0; i < 6; i++) begin
      tx_data  = 8'($urandom);
      tx_valid = 1'($urandom);
      cts      = 1'($urandom);
      sel      = 2'(i % 3);
      step;
      chk("rst_tx", o_tx, 1'b1);
      chk("rst_ready", o_rdy, 1'b1);
      chk("rst_busy", o_bsy, 1'b0);
      chk("rst_rts", o_rts, 1'b0);
      chk("rst_done", o_done, 1'b0);
    end
    tx_valid = 1'b0;
    cts      = 1'b1;
    sel      = 2'd0;
    rst_n    = 1'b1;
    repeat (3) step;

    accept(8'hA5);
    run_frame(8'hA5, 1, NONE, NONE);
    idle_check;

    // Random bytes with a stray 0x55 offered mid-frame that must be ignored.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) step;
      accept(b);
      run_frame(b, 1, $urandom_range(2, 30), NONE);
      idle_check;
    end

    cts = 1'b0;
    repeat (3) step;
    accept(8'h3C);
    for (int i = 0; i < 50; i++) begin
      step;
      chk("cts_hold_tx", o_tx, 1'b1);
      chk("cts_hold_rts", o_rts, 1'b1);
      chk("cts_hold_busy", o_bsy, 1'b1);
    end
    cts = 1'b1;
    step;
    chk("cts_sync_1", o_tx, 1'b1);
    step;
    chk("cts_sync_2", o_tx, 1'b1);
    run_frame(8'h3C, 1, NONE, 17);
    idle_check;
    cts = 1'b1;
    repeat (3) step;

    sel = 2'd1;
    chk("b2b_ready", o_rdy, 1'b1);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step;
    tx_data = 8'hFF;
    chk("b2b_busy1", o_bsy, 1'b1);
    chk("b2b_tx1", o_tx, 1'b1);
    run_frame(8'h00, 2, NONE, NONE);
    step;
    tx_valid = 1'b0;
    chk("b2b_accept2_ready", o_rdy, 1'b0);
    chk("b2b_accept2_busy", o_bsy, 1'b1);
    chk("b2b_accept2_rts", o_rts, 1'b1);
    chk("b2b_accept2_tx", o_tx, 1'b1);
    run_frame(8'hFF, 2, NONE, NONE);
    idle_check;

    sel = 2'd2;
    cts = 1'b0;
    repeat (3) step;
    accept(8'h81);
    run_frame(8'h81, 1, NONE, NONE);
    idle_check;

    sel = 2'd0;
    cts = 1'b1;
    repeat (3) step;
    accept(8'h00);
    for (int unsigned k = 0; k <= 10; k++) begin
      step;
      chk("pre_reset_line", o_tx, line_model(8'h00, k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx", o_tx, 1'b1);
    chk("midframe_rst_busy", o_bsy, 1'b0);
    chk("midframe_rst_ready", o_rdy, 1'b1);
    chk("midframe_rst_rts", o_rts, 1'b0);
    repeat (2) step;
    rst_n = 1'b1;
    repeat (3) step;
    b = 8'($urandom);
    accept(b);
    run_frame(b, 1, NONE, NONE);
    idle_check;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
